// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_detector_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILLING  = 2'd1,
    ARMED    = 2'd2
  } state_t;

  // Low `len` bits set; callers cast the result down to their own width (<= 32).
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) begin
      return '1;
    end
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector: compares the newest len bits of the input stream against a
// programmable pattern, pulses match one cycle later and counts matches.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int                   MAX_LEN     = 8,
  parameter int                   CNT_WIDTH   = 16,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = {{(MAX_LEN-1){1'b0}}, 1'b1},
  parameter int                   RST_LEN     = 2,
  parameter logic                 RST_OVERLAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_load,
  input  logic [MAX_LEN-1:0]       cfg_pattern,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                     cfg_overlap,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     match,
  output logic [CNT_WIDTH-1:0]     match_count,
  output logic                     armed
);

  localparam int               LEN_W     = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  // The oldest history bit is never compared again, so only MAX_LEN-1 bits are stored.
  logic [MAX_LEN-2:0] hist_reg, hist_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic [MAX_LEN-1:0] pat_reg, pat_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               ovl_reg, ovl_next;
  logic               match_reg, match_next;
  state_t             state_reg, state_next;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_plus;
  logic [LEN_W-1:0]   cfg_len_clamped;
  logic               hit;
  logic               count_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      pat_reg   <= RST_PATTERN;
      len_reg   <= LEN_W'(RST_LEN);
      ovl_reg   <= RST_OVERLAP;
      match_reg <= 1'b0;
      state_reg <= (RST_LEN == 0) ? DISABLED : FILLING;
    end else begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      ovl_reg   <= ovl_next;
      match_reg <= match_next;
      state_reg <= state_next;
    end
  end

  always_comb begin
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    ovl_next   = ovl_reg;
    match_next = 1'b0;
    state_next = state_reg;
    count_inc  = 1'b0;

    hist_shift      = {hist_reg, in_bit};
    fill_plus       = {1'b0, fill_reg} + (LEN_W + 1)'(1);
    mask            = MAX_LEN'(len_mask(32'(len_reg)));
    cfg_len_clamped = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
    // Judged on the history as it will be after this beat is shifted in.
    hit = (len_reg != '0) && (fill_plus >= {1'b0, len_reg}) &&
          (((hist_shift ^ pat_reg) & mask) == '0);

    if (cfg_load) begin
      // Reconfiguration wins over data: a beat presented alongside it is dropped.
      pat_next   = cfg_pattern;
      len_next   = cfg_len_clamped;
      ovl_next   = cfg_overlap;
      hist_next  = '0;
      fill_next  = '0;
      state_next = (cfg_len_clamped == '0) ? DISABLED : FILLING;
    end else if (in_valid) begin
      hist_next  = hist_shift[MAX_LEN-2:0];
      fill_next  = (fill_reg == MAX_LEN_L) ? fill_reg : fill_plus[LEN_W-1:0];
      match_next = hit;
      count_inc  = hit;
      if (hit && !ovl_reg) begin
        fill_next = '0;
      end
      if (len_reg == '0) begin
        state_next = DISABLED;
      end else if (fill_next >= len_reg) begin
        state_next = ARMED;
      end else begin
        state_next = FILLING;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_match_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (count_inc),
    .count (match_count)
  );

  assign match = match_reg;
  assign armed = (state_reg == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed checks of the sequence detector: defaults, reprogramming, overlap
// modes, counter saturation, async reset mid-stream and config edge cases.
module tb_seq_detector_param;

  logic       clk;
  logic       rst_n;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       in_bit;
  logic        match, match2;
  logic [15:0] count;
  logic [1:0]  count2;
  logic        armed, armed2;

  int checks = 0;
  int errors = 0;

  seq_detector_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .match_count (count),
    .armed       (armed)
  );

  // Narrow counter copy, used to see saturation quickly.
  seq_detector_param #(.CNT_WIDTH(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match2),
    .match_count (count2),
    .armed       (armed2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feeds n bits MSB first with in_valid held high; checks match/armed after each beat.
  task automatic run_stream(input logic [15:0] bits, input int n, input logic [15:0] exp_m,
                            input logic [15:0] exp_a, input string tag, input logic also2);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[n-1-i];
      @(posedge clk);
      #1;
      chk($sformatf("%s_match_b%0d", tag, i + 1), 32'(match), 32'(exp_m[n-1-i]));
      chk($sformatf("%s_armed_b%0d", tag, i + 1), 32'(armed), 32'(exp_a[n-1-i]));
      if (also2) chk($sformatf("%s_match2_b%0d", tag, i + 1), 32'(match2), 32'(exp_m[n-1-i]));
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input string tag);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    chk({tag, "_load_match"}, 32'(match), 32'd0);
    chk({tag, "_load_armed"}, 32'(armed), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_count2", 32'(count2), 32'd0);
    rst_n = 1'b1;

    // Defaults "01": five matches; 2-bit counter sticks at 3.
    run_stream(16'b0101010101, 10, 16'b0101010101, 16'b0111111111, "sat", 1'b1);
    chk("sat_count2", 32'(count2), 32'd3);
    chk("sat_count", 32'(count), 32'd5);

    do_reset();
    chk("rst2_count", 32'(count), 32'd0);
    run_stream(16'b1101110111011101, 16, 16'h1111, 16'h7FFF, "def", 1'b0);
    chk("def_count", 32'(count), 32'd4);

    load(8'b1101, 4'd4, 1'b1, "p1101");
    chk("p1101_kept_count", 32'(count), 32'd4);
    run_stream(16'b1101110111011101, 16, 16'h1111, 16'h1FFF, "p1101", 1'b0);
    chk("p1101_count", 32'(count), 32'd8);

    load(8'b11, 4'd2, 1'b1, "ovl");
    run_stream(16'b1111, 4, 16'b0111, 16'b0111, "ovl", 1'b0);
    chk("ovl_count", 32'(count), 32'd11);

    load(8'b11, 4'd2, 1'b0, "novl");
    run_stream(16'b1111, 4, 16'b0101, 16'b0000, "novl", 1'b0);
    chk("novl_count", 32'(count), 32'd13);

    // An idle cycle between beats holds the partial sequence.
    run_stream(16'b1, 1, 16'b0, 16'b0, "gap_a", 1'b0);
    @(posedge clk);
    #1;
    chk("gap_idle_match", 32'(match), 32'd0);
    run_stream(16'b1, 1, 16'b1, 16'b0, "gap_b", 1'b0);
    chk("gap_count", 32'(count), 32'd14);

    // Reset mid-sequence: partial 1101 discarded, config back to "01".
    load(8'b1101, 4'd4, 1'b1, "mid");
    run_stream(16'b110, 3, 16'b000, 16'b000, "mid_pre", 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_async_count", 32'(count), 32'd0);
    chk("mid_async_armed", 32'(armed), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_stream(16'b101, 3, 16'b001, 16'b011, "mid_post", 1'b0);
    chk("mid_count", 32'(count), 32'd1);

    // Load and beat in the same cycle: the beat must be dropped.
    cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1;
    cfg_load = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    chk("drop_match", 32'(match), 32'd0);
    chk("drop_armed", 32'(armed), 32'd0);
    run_stream(16'b11, 2, 16'b01, 16'b01, "drop", 1'b0);
    chk("drop_count", 32'(count), 32'd2);

    // Oversized length clamps to 8.
    load(8'hA5, 4'd12, 1'b1, "clamp");
    run_stream(16'hA5, 8, 16'h01, 16'h01, "clamp", 1'b0);
    chk("clamp_count", 32'(count), 32'd3);

    // Zero length disables detection.
    load(8'h00, 4'd0, 1'b1, "dis");
    run_stream(16'h00, 8, 16'h00, 16'h00, "dis0", 1'b0);
    run_stream(16'hFF, 8, 16'h00, 16'h00, "dis1", 1'b0);
    chk("dis_count", 32'(count), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
